decode_operand_reg: RTL and testbench

- Read side of the writeback path: the architectural register file, written by the writeback stage outputs (regwriteW, RdW, resultW) and read by decode.
- The two read operands, with their source and destination indices, are captured into the decode-to-execute pipeline register.
- The block pairs with writeback_stage_reg: that block drives the write port, this block consumes it and feeds execute.

---
 rtl/decode_operand_reg.sv | 95 +++++++++
 tb/tb_decode_operand_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/decode_operand_reg.sv
// Architectural register file (x0 hard-wired to zero) feeding the decode-to-execute pipeline register.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback straight into the operands captured for execute.
module decode_operand_reg #(
    parameter int               DPW         = 32,
    parameter logic [DPW-1:0]   REG_RST_VAL = '0
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            regwriteW,
    input  logic [4:0]      RdW,
    input  logic [DPW-1:0]  resultW,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic            stallD,
    input  logic            flushE,
    output logic [DPW-1:0]  RD1E,
    output logic [DPW-1:0]  RD2E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
);

    logic [DPW-1:0] regs_q  [1:31];
    logic [DPW-1:0] rf_view [0:31];
    logic [DPW-1:0] rd1_d;
    logic [DPW-1:0] rd2_d;
    logic [DPW-1:0] rd1e_q;
    logic [DPW-1:0] rd2e_q;
    logic [4:0]     rs1e_q;
    logic [4:0]     rs2e_q;
    logic [4:0]     rde_q;

    // x0 is never stored; slot 0 of the read view is a constant zero.
    assign rf_view[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    regs_q[gi] <= REG_RST_VAL;
                end else if (regwriteW && (RdW == 5'(gi))) begin
                    regs_q[gi] <= resultW;
                end
            end
            assign rf_view[gi] = regs_q[gi];
        end
    endgenerate

    always_comb begin
        rd1_d = rf_view[Rs1D];
        rd2_d = rf_view[Rs2D];
`ifdef REGFILE_BYPASS_EN
        if (regwriteW && (RdW != 5'd0) && (RdW == Rs1D)) begin
            rd1_d = resultW;
        end
        if (regwriteW && (RdW != 5'd0) && (RdW == Rs2D)) begin
            rd2_d = resultW;
        end
`else
        // Same-cycle writes are not visible here; the hazard unit covers that case.
`endif
    end

    // Flush beats stall: a bubble carries RdE=0 so nothing downstream writes back.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd1e_q <= '0;
            rd2e_q <= '0;
            rs1e_q <= '0;
            rs2e_q <= '0;
            rde_q  <= '0;
        end else if (flushE) begin
            rd1e_q <= '0;
            rd2e_q <= '0;
            rs1e_q <= '0;
            rs2e_q <= '0;
            rde_q  <= '0;
        end else if (!stallD) begin
            rd1e_q <= rd1_d;
            rd2e_q <= rd2_d;
            rs1e_q <= Rs1D;
            rs2e_q <= Rs2D;
            rde_q  <= RdD;
        end
    end

    assign RD1E = rd1e_q;
    assign RD2E = rd2e_q;
    assign Rs1E = rs1e_q;
    assign Rs2E = rs2e_q;
    assign RdE  = rde_q;

endmodule

// File: tb/tb_decode_operand_reg.sv
// Self-checking bench for decode_operand_reg: directed vector table, mid-cycle reset, randomized model check.
// Expectations follow REGFILE_BYPASS_EN when the macro is defined for the build.
module tb_decode_operand_reg;

    localparam logic [31:0] RST_VAL = 32'h0000_00A5;
`ifdef REGFILE_BYPASS_EN
    localparam bit          BYP    = 1'b1;
    localparam logic [31:0] BYP_E2 = 32'd2;
`else
    localparam bit          BYP    = 1'b0;
    localparam logic [31:0] BYP_E2 = RST_VAL;
`endif

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        regwriteW = 1'b0;
    logic [4:0]  RdW = '0;
    logic [31:0] resultW = '0;
    logic [4:0]  Rs1D = '0;
    logic [4:0]  Rs2D = '0;
    logic [4:0]  RdD = '0;
    logic        stallD = 1'b0;
    logic        flushE = 1'b0;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_operand_reg #(.DPW(32), .REG_RST_VAL(RST_VAL)) dut (
        .clk(clk), .arst_n(arst_n),
        .regwriteW(regwriteW), .RdW(RdW), .resultW(resultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .stallD(stallD), .flushE(flushE),
        .RD1E(RD1E), .RD2E(RD2E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rdw;
        logic [31:0] res;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        stall;
        logic        flush;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [4:0]  ers1;
        logic [4:0]  ers2;
        logic [4:0]  erd;
    } vec_t;

    vec_t tbl [14];

    // Reference state for the random phase
    logic [31:0] mrf [32];
    logic [31:0] m_e1, m_e2;
    logic [4:0]  m_rs1, m_rs2, m_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [4:0] ers1, input logic [4:0] ers2, input logic [4:0] erd);
        chk({tag, ".RD1E"}, RD1E, e1);
        chk({tag, ".RD2E"}, RD2E, e2);
        chk({tag, ".Rs1E"}, 32'(Rs1E), 32'(ers1));
        chk({tag, ".Rs2E"}, 32'(Rs2E), 32'(ers2));
        chk({tag, ".RdE"},  32'(RdE),  32'(erd));
    endtask

    // Drive one cycle of inputs (called ~1 time unit after a rising edge), wait for the next edge.
    task automatic drive_cycle(input logic we, input logic [4:0] rdw, input logic [31:0] res,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic stall, input logic flush);
        regwriteW = we; RdW = rdw; resultW = res;
        Rs1D = rs1; Rs2D = rs2; RdD = rd;
        stallD = stall; flushE = flush;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Directed table: reset state is RST_VAL in x1..x31.
        tbl[0]  = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd0, 5'd1, 1'b0, 1'b0, RST_VAL,       32'h0,         5'd5, 5'd0, 5'd1};
        tbl[1]  = '{1'b1, 5'd3, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0,         32'h0,         5'd0, 5'd0, 5'd0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,         5'd3, 5'd3, 5'd2, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd3, 5'd3, 5'd2};
        tbl[3]  = '{1'b1, 5'd0, 32'h5,         5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF, 5'd0, 5'd3, 5'd0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0,         32'h0,         5'd0, 5'd0, 5'd0};
        tbl[5]  = '{1'b1, 5'd7, 32'h2,         5'd3, 5'd7, 5'd8, 1'b0, 1'b0, 32'hDEAD_BEEF, BYP_E2,        5'd3, 5'd7, 5'd8};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd7, 5'd8, 1'b0, 1'b0, 32'h0,         32'h2,         5'd0, 5'd7, 5'd8};
        tbl[7]  = '{1'b1, 5'd4, 32'h9,         5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0,         32'h0,         5'd0, 5'd0, 5'd0};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,         5'd4, 5'd7, 5'd9, 1'b0, 1'b0, 32'h9,         32'h2,         5'd4, 5'd7, 5'd9};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,         5'd6, 5'd3, 5'd5, 1'b1, 1'b0, 32'h9,         32'h2,         5'd4, 5'd7, 5'd9};
        tbl[10] = '{1'b1, 5'd4, 32'd11,        5'd4, 5'd3, 5'd5, 1'b1, 1'b0, 32'h9,         32'h2,         5'd4, 5'd7, 5'd9};
        tbl[11] = '{1'b0, 5'd0, 32'h0,         5'd4, 5'd3, 5'd5, 1'b1, 1'b1, 32'h0,         32'h0,         5'd0, 5'd0, 5'd0};
        tbl[12] = '{1'b0, 5'd0, 32'h0,         5'd4, 5'd0, 5'd3, 1'b0, 1'b0, 32'd11,        32'h0,         5'd4, 5'd0, 5'd3};
        tbl[13] = '{1'b1, 5'd31, 32'h1234_5678, 5'd3, 5'd31, 5'd31, 1'b0, 1'b0, 32'hDEAD_BEEF,
                    BYP ? 32'h1234_5678 : RST_VAL, 5'd3, 5'd31, 5'd31};

        // Reset state while arst_n is held low from time 0
        #2;
        chk_all("reset0", 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        $display("txn reset0 RD1E=%h RD2E=%h RdE=%0d", RD1E, RD2E, RdE);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            drive_cycle(tbl[i].we, tbl[i].rdw, tbl[i].res, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                        tbl[i].stall, tbl[i].flush);
            chk_all($sformatf("vec%0d", i), tbl[i].e1, tbl[i].e2, tbl[i].ers1, tbl[i].ers2, tbl[i].erd);
            $display("txn vec%0d RD1E=%h RD2E=%h Rs1E=%0d Rs2E=%0d RdE=%0d",
                     i, RD1E, RD2E, Rs1E, Rs2E, RdE);
        end

        // Mid-cycle asynchronous reset with non-zero E outputs: must clear before any edge.
        regwriteW = 1'b0; stallD = 1'b0; flushE = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        $display("txn async_rst RD1E=%h RD2E=%h RdE=%0d", RD1E, RD2E, RdE);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        // Written registers must have returned to the reset value.
        drive_cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd4, 5'd0, 1'b0, 1'b0);
        chk_all("post_rst", RST_VAL, RST_VAL, 5'd5, 5'd4, 5'd0);
        $display("txn post_rst RD1E=%h RD2E=%h", RD1E, RD2E);

        // Randomized phase against a register-array model
        mrf[0] = 32'h0;
        for (int r = 1; r < 32; r++) mrf[r] = RST_VAL;
        m_e1 = RST_VAL; m_e2 = RST_VAL; m_rs1 = 5'd5; m_rs2 = 5'd4; m_rd = 5'd0;
        for (int n = 0; n < 400; n++) begin
            logic        we, st, fl;
            logic [4:0]  rdw, rs1, rs2, rd;
            logic [31:0] res, v1, v2;
            we  = ($urandom_range(0, 1) == 1);
            rdw = 5'($urandom_range(0, 31));
            res = $urandom;
            rs1 = ($urandom_range(0, 3) == 0) ? rdw : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? rdw : 5'($urandom_range(0, 31));
            rd  = 5'($urandom_range(0, 31));
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            v1 = (rs1 == 5'd0) ? 32'h0 : mrf[rs1];
            v2 = (rs2 == 5'd0) ? 32'h0 : mrf[rs2];
            if (BYP && we && rdw != 5'd0) begin
                if (rdw == rs1) v1 = res;
                if (rdw == rs2) v2 = res;
            end
            if (fl) begin
                m_e1 = 32'h0; m_e2 = 32'h0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0;
            end else if (!st) begin
                m_e1 = v1; m_e2 = v2; m_rs1 = rs1; m_rs2 = rs2; m_rd = rd;
            end
            if (we && rdw != 5'd0) mrf[rdw] = res;
            drive_cycle(we, rdw, res, rs1, rs2, rd, st, fl);
            chk_all($sformatf("rnd%0d", n), m_e1, m_e2, m_rs1, m_rs2, m_rd);
            $display("txn rnd%0d we=%0d RdW=%0d Rs1D=%0d Rs2D=%0d st=%0d fl=%0d RD1E=%h RD2E=%h",
                     n, we, rdw, rs1, rs2, st, fl, RD1E, RD2E);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
